cost_table: RTL and testbench

COST_TABLE -- requirements
Module: cost_table

---
 rtl/jam_pkg.sv | 18 +
 rtl/cost_regfile.sv | 33 +++
 rtl/cost_table.sv | 108 ++++++++++
 tb/tb_cost_table.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared definitions for the cost table and the assignment engine.
//   N_W / N_J / CW : table geometry and cost entry width
//   CSW            : checksum width (64 entries * 127 max fits in 13 bits)
//   load_state_e   : cost table load FSM encoding (IDLE=0, LOAD=1, READY=2)
package jam_pkg;

    localparam int unsigned N_W = 8;
    localparam int unsigned N_J = 8;
    localparam int unsigned CW  = 7;
    localparam int unsigned CSW = 13;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StReady = 2'd2
    } load_state_e;

endpackage

// File: rtl/cost_regfile.sv
// Cost storage: register array with one synchronous write port and one
// combinational read port. Deliberately has no reset; contents survive
// reset and reload until overwritten.
//   CLK   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module cost_regfile #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 7,
    localparam int unsigned AW   = $clog2(Depth)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cost_table.sv
// Worker/job cost table. Loads N_W*N_J cost entries row-major from a
// valid/ready stream, then serves combinational lookups for the assignment
// engine. A reload request in READY restarts the load.
//   CLK, RST    : clock; asynchronous active-high reset
//   in_valid    : load stream entry present
//   in_data     : load stream cost entry
//   in_ready    : high while loading
//   reload      : single-cycle request to reload the table (honoured in READY)
//   W, J        : worker / job lookup index
//   Cost        : mem[{W,J}] in READY, else 0
//   table_ready : full table loaded
//   checksum    : sum of entries accepted since the current load started
module cost_table
    import jam_pkg::*;
#(
    parameter int unsigned N_W = jam_pkg::N_W,
    parameter int unsigned N_J = jam_pkg::N_J,
    parameter int unsigned CW  = jam_pkg::CW,
    localparam int unsigned WW = $clog2(N_W),
    localparam int unsigned JW = $clog2(N_J)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    input  logic [CW-1:0]  in_data,
    output logic           in_ready,
    input  logic           reload,
    input  logic [WW-1:0]  W,
    input  logic [JW-1:0]  J,
    output logic [CW-1:0]  Cost,
    output logic           table_ready,
    output logic [CSW-1:0] checksum
);

    localparam int unsigned Entries = N_W * N_J;
    localparam int unsigned AW      = $clog2(Entries);

    load_state_e    state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [CSW-1:0] checksum_q, checksum_d;
    logic           accept;
    logic [CW-1:0]  rd_data;

    assign accept = in_valid && (state_q == StLoad);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        checksum_d = checksum_q;
        unique case (state_q)
            StIdle: begin
                state_d = StLoad;
            end
            StLoad: begin
                if (accept) begin
                    // addr wraps to 0 on the last entry, ready for a later reload
                    addr_d     = addr_q + AW'(1);
                    checksum_d = checksum_q + CSW'(in_data);
                    if (addr_q == AW'(Entries - 1)) begin
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                if (reload) begin
                    state_d    = StLoad;
                    addr_d     = '0;
                    checksum_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            checksum_q <= checksum_d;
        end
    end

    cost_regfile #(
        .Depth (Entries),
        .Width (CW)
    ) u_regfile (
        .CLK   (CLK),
        .we    (accept),
        .waddr (addr_q),
        .wdata (in_data),
        .raddr ({W, J}),
        .rdata (rd_data)
    );

    assign in_ready    = (state_q == StLoad);
    assign table_ready = (state_q == StReady);
    // Lookup is combinational: the engine drives W/J on a rising edge and
    // samples Cost on the following falling edge.
    assign Cost        = table_ready ? rd_data : '0;
    assign checksum    = checksum_q;

endmodule

// File: tb/tb_cost_table.sv
// Self-checking bench for cost_table: directed phases with random data,
// checked against a behavioural model of the table (entry count, ready
// flag, running sum and a 64-entry cost array).
module tb_cost_table;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [6:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        table_ready;
    logic [12:0] checksum;

    cost_table dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .reload      (reload),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .table_ready (table_ready),
        .checksum    (checksum)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model
    bit m_started;
    bit m_ready;
    int m_count;
    int m_cksum;
    int m_mem [64];

    task automatic model_reset();
        m_started = 1'b0;
        m_ready   = 1'b0;
        m_count   = 0;
        m_cksum   = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_cost();
        return m_ready ? m_mem[int'({W, J})] : 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_started && !m_ready));
        chk({tag, ".table_ready"}, 32'(table_ready), 32'(m_ready));
        chk({tag, ".checksum"}, 32'(checksum), 32'(m_cksum));
        chk({tag, ".cost"}, 32'(Cost), 32'(exp_cost()));
    endtask

    // One clock edge: advance the model with the pre-edge inputs, then check.
    task automatic tick(input string tag);
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_ready) begin
            if (reload) begin
                m_ready = 1'b0;
                m_count = 0;
                m_cksum = 0;
            end
        end else if (in_valid) begin
            m_mem[m_count] = int'(in_data);
            m_cksum += int'(in_data);
            m_count++;
            if (m_count == 64) begin
                m_ready = 1'b1;
                m_count = 0;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int saved_cost;
        int saved_cksum;
        int accepted;
        int cyc;

        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        reload   = 1'b0;
        W        = '0;
        J        = '0;
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick("idle_to_load");
        chk("load.in_ready", 32'(in_ready), 32'd1);

        // Back-to-back load of (row*8+col)
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 7'(i);
            W        = 3'($urandom);
            J        = 3'($urandom);
            tick("a.load");
            chk("a.ready_edge", 32'(table_ready), 32'(i == 63));
        end
        in_valid = 1'b0;
        W = 3'd5;
        J = 3'd3;
        #1;
        chk("a.cost_w5j3", 32'(Cost), 32'd43);
        chk("a.checksum", 32'(checksum), 32'd2016);
        for (int i = 0; i < 16; i++) begin
            W = 3'($urandom);
            J = 3'($urandom);
            tick("a.lookup");
        end

        // Reload, then alternating valid with random data and ignored reloads
        reload = 1'b1;
        tick("b.reload");
        reload = 1'b0;
        chk("b.not_ready_after_reload", 32'(table_ready), 32'd0);
        for (int c = 0; c < 127; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 7'($urandom);
            W        = 3'($urandom);
            J        = 3'($urandom);
            reload   = ($urandom_range(0, 3) == 0);
            tick("b.load");
            chk("b.ready_edge", 32'(table_ready), 32'(c == 126));
            chk("b.cost_zero", 32'(Cost), (c == 126) ? 32'(exp_cost()) : 32'd0);
        end
        reload   = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            W = 3'($urandom);
            J = 3'($urandom);
            tick("b.lookup");
        end

        // in_valid in READY is ignored
        W = 3'd0;
        J = 3'd0;
        #1;
        saved_cost  = m_mem[0];
        saved_cksum = m_cksum;
        in_valid    = 1'b1;
        in_data     = 7'd99;
        for (int i = 0; i < 10; i++) begin
            tick("c.ready_valid");
            chk("c.in_ready", 32'(in_ready), 32'd0);
            chk("c.checksum", 32'(checksum), 32'(saved_cksum));
            chk("c.cost00", 32'(Cost), 32'(saved_cost));
        end
        in_valid = 1'b0;

        // Reload with all-127 entries
        reload = 1'b1;
        tick("d.reload");
        reload = 1'b0;
        chk("d.not_ready_after_reload", 32'(table_ready), 32'd0);
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 7'd127;
            tick("d.load");
        end
        in_valid = 1'b0;
        chk("d.ready", 32'(table_ready), 32'd1);
        chk("d.checksum", 32'(checksum), 32'd8128);
        for (int i = 0; i < 64; i++) begin
            W = 3'(i / 8);
            J = 3'(i % 8);
            #1;
            chk("d.cost127", 32'(Cost), 32'd127);
        end

        // Reset after 30 accepted entries
        reload = 1'b1;
        tick("e.reload");
        reload   = 1'b0;
        accepted = 0;
        cyc      = 0;
        while (accepted < 30 && cyc < 500) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 7'($urandom);
            if (in_valid) accepted++;
            tick("e.partial");
            cyc++;
        end
        in_valid = 1'b0;
        chk("e.partial_cksum_live", 32'(checksum), 32'(m_cksum));
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk("e.rst_table_ready", 32'(table_ready), 32'd0);
        chk("e.rst_checksum", 32'(checksum), 32'd0);
        chk("e.rst_in_ready", 32'(in_ready), 32'd0);
        chk("e.rst_cost", 32'(Cost), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick("e.idle_to_load");
        cyc = 0;
        while (!m_ready && cyc < 1000) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 7'($urandom);
            W        = 3'($urandom);
            J        = 3'($urandom);
            reload   = ($urandom_range(0, 7) == 0);
            tick("e.reload_full");
            cyc++;
        end
        in_valid = 1'b0;
        reload   = 1'b0;
        chk("e.ready", 32'(table_ready), 32'd1);
        for (int i = 0; i < 64; i++) begin
            W = 3'(i / 8);
            J = 3'(i % 8);
            #1;
            chk("e.cost", 32'(Cost), 32'(m_mem[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
